// File: rtl/pingpong_scheduler_pkg.sv
// Shared types and default sizing for the ping-pong tile scheduler (package tpu_sched_pkg).
package tpu_sched_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FILLING   = 2'd1,
    FULL      = 2'd2,
    COMPUTING = 2'd3
  } bufState_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } schedState_t;

  localparam int unsigned DEFAULT_MATRIX_SIZE = 8;
  localparam int unsigned DEFAULT_MAX_TILES   = 16;
  localparam int unsigned ROW_W  = $clog2(DEFAULT_MATRIX_SIZE);
  localparam int unsigned TILE_W = $clog2(DEFAULT_MAX_TILES + 1);

endpackage

// File: rtl/pingpong_buffer_state.sv
// Lifecycle tracker for one ping-pong buffer: EMPTY -> FILLING -> FULL -> COMPUTING -> EMPTY.
module pingpong_buffer_state
  import tpu_sched_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      fillStart,
  input  logic      fillEnd,
  input  logic      computeBegin,
  input  logic      computeEnd,
  output bufState_t state,
  output logic      isFree,
  output logic      isFull
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        // fillEnd wins so a one-row buffer goes straight to FULL
        EMPTY:     if (fillEnd) state <= FULL;
                   else if (fillStart) state <= FILLING;
        FILLING:   if (fillEnd) state <= FULL;
        FULL:      if (computeBegin) state <= COMPUTING;
        COMPUTING: if (computeEnd) state <= EMPTY;
        default:   state <= EMPTY;
      endcase
    end
  end

  assign isFree = (state == EMPTY) || (state == FILLING);
  assign isFull = (state == FULL);

endmodule

// File: rtl/pingpong_scheduler.sv
// Job sequencer steering row loads into ping-pong buffers and issuing TPU compute starts.
// Optional sticky protocolError output enabled by defining PINGPONG_SCHED_ERR_EN.
module pingpong_scheduler
  import tpu_sched_pkg::*;
#(
  parameter int unsigned matrixSize = DEFAULT_MATRIX_SIZE,
  parameter int unsigned maxTiles   = DEFAULT_MAX_TILES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          jobStart,
  input  logic [$clog2(maxTiles+1)-1:0] tileCount,
  input  logic                          loadValid,
  output logic                          loadReady,
  output logic [$clog2(matrixSize)-1:0] loadRowIndex,
  output logic                          loadBuffer,
  output logic                          computeStart,
  output logic                          computeBuffer,
  input  logic                          computeDone,
  output logic [1:0]                    bufferFull,
  output logic                          jobBusy,
  output logic                          jobDone,
  output logic [$clog2(maxTiles+1)-1:0] tilesCompleted
`ifdef PINGPONG_SCHED_ERR_EN
  ,
  output logic                          protocolError
`endif
);

  localparam int unsigned RW = $clog2(matrixSize);
  localparam int unsigned CW = $clog2(maxTiles + 1);

  schedState_t   state;
  logic [CW-1:0] tileTarget;
  logic [CW-1:0] tilesLoaded;
  logic          computing;
  bufState_t     bstateA, bstateB;
  logic [1:0]    isFree, isFull;
  logic [1:0]    fillStart, fillEnd, computeBegin, computeEnd;
  logic          accept, lastRow, retire;

  assign loadReady    = (state == RUN) && isFree[loadBuffer] && (tilesLoaded < tileTarget);
  assign accept       = loadValid && loadReady;
  assign lastRow      = (loadRowIndex == RW'(matrixSize - 1));
  assign computeStart = (state == RUN) && !computing && isFull[computeBuffer];
  assign retire       = computeDone && computing;

  assign fillStart    = {accept &&  loadBuffer && (loadRowIndex == '0),
                         accept && !loadBuffer && (loadRowIndex == '0)};
  assign fillEnd      = {accept &&  loadBuffer && lastRow,
                         accept && !loadBuffer && lastRow};
  assign computeBegin = {computeStart &&  computeBuffer, computeStart && !computeBuffer};
  assign computeEnd   = {retire &&  computeBuffer, retire && !computeBuffer};

  pingpong_buffer_state bufA (
    .clk(clk), .reset(reset),
    .fillStart(fillStart[0]), .fillEnd(fillEnd[0]),
    .computeBegin(computeBegin[0]), .computeEnd(computeEnd[0]),
    .state(bstateA), .isFree(isFree[0]), .isFull(isFull[0])
  );

  pingpong_buffer_state bufB (
    .clk(clk), .reset(reset),
    .fillStart(fillStart[1]), .fillEnd(fillEnd[1]),
    .computeBegin(computeBegin[1]), .computeEnd(computeEnd[1]),
    .state(bstateB), .isFree(isFree[1]), .isFull(isFull[1])
  );

  assign bufferFull = {(bstateB == FULL) || (bstateB == COMPUTING),
                       (bstateA == FULL) || (bstateA == COMPUTING)};
  assign jobBusy    = (state != IDLE);
  assign jobDone    = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      tileTarget     <= '0;
      tilesLoaded    <= '0;
      tilesCompleted <= '0;
      loadRowIndex   <= '0;
      loadBuffer     <= 1'b0;
      computeBuffer  <= 1'b0;
      computing      <= 1'b0;
    end else begin
      if (accept) begin
        if (lastRow) begin
          loadRowIndex <= '0;
          loadBuffer   <= ~loadBuffer;
          tilesLoaded  <= tilesLoaded + CW'(1);
        end else begin
          loadRowIndex <= loadRowIndex + RW'(1);
        end
      end
      if (computeStart) computing <= 1'b1;
      if (retire) begin
        computing      <= 1'b0;
        computeBuffer  <= ~computeBuffer;
        tilesCompleted <= tilesCompleted + CW'(1);
      end
      unique case (state)
        IDLE: if (jobStart) begin
          // every job begins on buffer A, even after an odd tile count
          tileTarget     <= tileCount;
          tilesLoaded    <= '0;
          tilesCompleted <= '0;
          loadRowIndex   <= '0;
          loadBuffer     <= 1'b0;
          computeBuffer  <= 1'b0;
          computing      <= 1'b0;
          state          <= (tileCount == '0) ? DONE : RUN;
        end
        RUN:     if (retire && (tilesCompleted + CW'(1) == tileTarget)) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PINGPONG_SCHED_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      protocolError <= 1'b0;
    end else if ((jobStart && (state != IDLE)) ||
                 (computeDone && !computing) ||
                 (jobStart && (tileCount > CW'(maxTiles)))) begin
      protocolError <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_scheduler.sv
// Scoreboard bench for pingpong_scheduler; define PINGPONG_SCHED_ERR_EN to cover protocolError.
module tb_pingpong_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       jobStart = 1'b0;
  logic [4:0] tileCount = '0;
  logic       loadValid = 1'b0;
  logic       loadReady;
  logic [2:0] loadRowIndex;
  logic       loadBuffer;
  logic       computeStart;
  logic       computeBuffer;
  logic       computeDone = 1'b0;
  logic [1:0] bufferFull;
  logic       jobBusy;
  logic       jobDone;
  logic [4:0] tilesCompleted;
`ifdef PINGPONG_SCHED_ERR_EN
  logic       protocolError;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit b;
    int fill;
  } sb_t;
  sb_t sbq[$];

  int stReady, stFirstStall, stAccept8, stAccept17, stFirstDone;

  always #5 clk = ~clk;

  pingpong_scheduler #(.matrixSize(8), .maxTiles(16)) dut (
    .clk(clk), .reset(reset), .jobStart(jobStart), .tileCount(tileCount),
    .loadValid(loadValid), .loadReady(loadReady), .loadRowIndex(loadRowIndex),
    .loadBuffer(loadBuffer), .computeStart(computeStart), .computeBuffer(computeBuffer),
    .computeDone(computeDone), .bufferFull(bufferFull), .jobBusy(jobBusy),
    .jobDone(jobDone), .tilesCompleted(tilesCompleted)
`ifdef PINGPONG_SCHED_ERR_EN
    , .protocolError(protocolError)
`endif
  );

  // mode 0: loadValid held high; mode 1: alternates starting high. lat: TPU cycles to done.
  task automatic run_job(input int tiles, input int mode, input int lat);
    int  timer, mRow, mBuf, mCompleted, accepts, lastDone, expStart;
    bit  expectDone, done;
    sb_t e;
    sbq.delete();
    stReady = 0; stFirstStall = -1; stAccept8 = -1; stAccept17 = -1; stFirstDone = -1;
    mRow = 0; mBuf = 0; mCompleted = 0; accepts = 0; lastDone = 0; timer = 0;
    expectDone = 0; done = 0;
    @(posedge clk); #1;
    jobStart = 1'b1; tileCount = 5'(tiles); loadValid = 1'b0; computeDone = 1'b0;
    @(negedge clk);
    checks++;
    if (jobBusy !== 1'b0) begin errors++; $display("FAIL busy_at_start: got %b want 0", jobBusy); end
    for (int c = 1; c <= 2000 && !done; c++) begin
      @(posedge clk); #1;
      jobStart = 1'b0;
      computeDone = 1'b0;
      if (timer > 0) begin
        timer--;
        if (timer == 0) computeDone = 1'b1;
      end
      loadValid = (mode == 0) ? 1'b1 : ((c % 2) == 1);
      @(negedge clk);
      checks++;
      if (jobBusy !== 1'b1) begin errors++; $display("FAIL busy_in_job: cycle %0d got %b want 1", c, jobBusy); end
      if (expectDone) begin
        checks++;
        if (jobDone !== 1'b1) begin errors++; $display("FAIL job_done: got %b want 1", jobDone); end
        checks++;
        if (tilesCompleted !== 5'(tiles))
          begin errors++; $display("FAIL tiles_completed_end: got %0d want %0d", tilesCompleted, tiles); end
        done = 1;
      end else begin
        checks++;
        if (jobDone !== 1'b0) begin errors++; $display("FAIL early_job_done: cycle %0d got %b want 0", c, jobDone); end
        checks++;
        if (loadRowIndex !== 3'(mRow) || loadBuffer !== 1'(mBuf))
          begin errors++; $display("FAIL load_slot: cycle %0d got buf %0d row %0d want buf %0d row %0d",
                                   c, loadBuffer, loadRowIndex, mBuf, mRow); end
        checks++;
        if (tilesCompleted !== 5'(mCompleted))
          begin errors++; $display("FAIL tiles_completed: cycle %0d got %0d want %0d", c, tilesCompleted, mCompleted); end
        if (loadReady) stReady++;
        if (loadValid && !loadReady && stFirstStall < 0) stFirstStall = c;
        if (loadValid && loadReady) begin
          accepts++;
          if (accepts == 8) stAccept8 = c;
          if (accepts == 17) stAccept17 = c;
          if (mRow == 7) begin
            sbq.push_back('{b: mBuf[0], fill: c});
            mRow = 0;
            mBuf ^= 1;
          end else begin
            mRow++;
          end
        end
        if (computeStart) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++; $display("FAIL unexpected_start: cycle %0d got start with no full tile", c);
          end else begin
            e = sbq.pop_front();
            if (computeBuffer !== e.b)
              begin errors++; $display("FAIL compute_buffer: got %0d want %0d", computeBuffer, e.b); end
            expStart = ((e.fill > lastDone) ? e.fill : lastDone) + 1;
            checks++;
            if (c != expStart) begin errors++; $display("FAIL start_cycle: got %0d want %0d", c, expStart); end
            timer = lat;
          end
        end
        if (computeDone) begin
          mCompleted++;
          lastDone = c;
          if (stFirstDone < 0) stFirstDone = c;
          if (mCompleted == tiles) expectDone = 1;
        end
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL job_timeout: got no jobDone want jobDone within 2000 cycles"); end
    loadValid = 1'b0;
    computeDone = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({loadReady, loadRowIndex, loadBuffer, computeStart, computeBuffer, bufferFull,
         jobBusy, jobDone, tilesCompleted} !== '0)
      begin errors++; $display("FAIL reset_outputs: got nonzero output want all 0"); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    run_job(1, 0, 3);
    checks++;
    if (stReady != 8) begin errors++; $display("FAIL single_ready_cycles: got %0d want 8", stReady); end
    checks++;
    if (stAccept8 != 8) begin errors++; $display("FAIL single_accept8: got %0d want 8", stAccept8); end
  endtask

  task automatic test_overlap();
    run_job(3, 0, 20);
    checks++;
    if (stFirstStall != 17) begin errors++; $display("FAIL overlap_first_stall: got %0d want 17", stFirstStall); end
    checks++;
    if (stAccept17 != stFirstDone + 1)
      begin errors++; $display("FAIL overlap_resume: got %0d want %0d", stAccept17, stFirstDone + 1); end
  endtask

  task automatic test_zero();
    @(posedge clk); #1;
    jobStart = 1'b1; tileCount = 5'd0; loadValid = 1'b1;
    @(posedge clk); #1;
    jobStart = 1'b0;
    @(negedge clk);
    checks++;
    if (jobDone !== 1'b1) begin errors++; $display("FAIL zero_job_done: got %b want 1", jobDone); end
    checks++;
    if (loadReady !== 1'b0 || computeStart !== 1'b0)
      begin errors++; $display("FAIL zero_activity: got ready %b start %b want 0 0", loadReady, computeStart); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({loadReady, computeStart, jobDone, jobBusy} !== 4'b0)
        begin errors++; $display("FAIL zero_idle: got ready %b start %b done %b busy %b want 0 0 0 0",
                                 loadReady, computeStart, jobDone, jobBusy); end
    end
    loadValid = 1'b0;
  endtask

  task automatic test_backpressure();
    run_job(2, 1, 4);
    checks++;
    if (stAccept8 != 15) begin errors++; $display("FAIL bp_accept8: got %0d want 15", stAccept8); end
  endtask

  task automatic test_reset_midfill();
    @(posedge clk); #1;
    jobStart = 1'b1; tileCount = 5'd2;
    @(posedge clk); #1;
    jobStart = 1'b0; loadValid = 1'b1;
    repeat (4) @(posedge clk);
    #1 loadValid = 1'b0;
    @(negedge clk);
    checks++;
    if (loadRowIndex !== 3'd4) begin errors++; $display("FAIL midfill_row: got %0d want 4", loadRowIndex); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({loadReady, loadRowIndex, loadBuffer, computeStart, computeBuffer, bufferFull,
         jobBusy, jobDone, tilesCompleted} !== '0)
      begin errors++; $display("FAIL midfill_reset_outputs: got nonzero output want all 0"); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_job(1, 0, 2);
  endtask

`ifdef PINGPONG_SCHED_ERR_EN
  task automatic test_error();
    @(negedge clk);
    checks++;
    if (protocolError !== 1'b0) begin errors++; $display("FAIL err_initial: got %b want 0", protocolError); end
    @(posedge clk); #1 computeDone = 1'b1;
    @(posedge clk); #1 computeDone = 1'b0;
    @(negedge clk);
    checks++;
    if (protocolError !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", protocolError); end
    run_job(1, 0, 2);
    @(negedge clk);
    checks++;
    if (protocolError !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", protocolError); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (protocolError !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", protocolError); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_zero();
    test_backpressure();
    test_reset_midfill();
`ifdef PINGPONG_SCHED_ERR_EN
    test_error();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
